perf_counter_unit: RTL and testbench

//  In-core performance/retirement counter block fed by the MEM/WB-stage event strobes (reg write,
//  mem write, halt) and the I/D cache request/hit strobes. Keeps cycle, retired-instruction and

---
 rtl/perf_counter_unit.sv | 99 +++++++++
 tb/tb_perf_counter_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_unit.sv
// Cycle / retired-instruction / cache request+hit counters with a registered read port.
// Optional build macro: PERF_SAT_EN (counters saturate at all-ones instead of wrapping).
module perf_counter_unit #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             reg_write,
  input  logic             mem_write,
  input  logic             halt,
  input  logic             icache_req,
  input  logic             icache_hit,
  input  logic             dcache_req,
  input  logic             dcache_hit,
  input  logic             clr,
  input  logic             rd_en,
  input  logic [2:0]       rd_sel,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_data,
  output logic [5:0]       ovf,
  output logic             halted
);

  logic [CNT_W-1:0] cnt_q [6];
  logic [CNT_W-1:0] cnt_d [6];
  logic [5:0]       ovf_q, ovf_d;
  logic             halted_q, halted_d;
  logic             rd_valid_q;
  logic [CNT_W-1:0] rd_data_q;
  logic [CNT_W-1:0] rd_mux;
  logic [5:0]       inc;

  // Bit order matches the rd_sel / ovf encoding.
  assign inc = {dcache_req & dcache_hit, dcache_req, icache_req & icache_hit, icache_req,
                reg_write | mem_write | halt, 1'b1};

  always_comb begin
    for (int i = 0; i < 6; i++) cnt_d[i] = cnt_q[i];
    ovf_d    = ovf_q;
    halted_d = halted_q;
    if (clr) begin
      for (int i = 0; i < 6; i++) cnt_d[i] = '0;
      ovf_d    = '0;
      halted_d = 1'b0;
    end else if (!halted_q) begin
      for (int i = 0; i < 6; i++) begin
        if (inc[i]) begin
          if (&cnt_q[i]) begin
            ovf_d[i] = 1'b1;
`ifdef PERF_SAT_EN
            cnt_d[i] = cnt_q[i];
`else
            cnt_d[i] = '0;
`endif
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
      end
      if (halt) halted_d = 1'b1;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (rd_sel)
      3'd0:    rd_mux = cnt_q[0];
      3'd1:    rd_mux = cnt_q[1];
      3'd2:    rd_mux = cnt_q[2];
      3'd3:    rd_mux = cnt_q[3];
      3'd4:    rd_mux = cnt_q[4];
      3'd5:    rd_mux = cnt_q[5];
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) cnt_q[i] <= '0;
      ovf_q      <= '0;
      halted_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      for (int i = 0; i < 6; i++) cnt_q[i] <= cnt_d[i];
      ovf_q      <= ovf_d;
      halted_q   <= halted_d;
      rd_valid_q <= rd_en;
      // Sampled from cnt_q, so a read alongside clr returns the pre-clear value.
      if (rd_en) rd_data_q <= rd_mux;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign ovf      = ovf_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_perf_counter_unit.sv
// Self-checking bench for perf_counter_unit (CNT_W=8) with a read-data scoreboard.
module tb_perf_counter_unit;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         reg_write = 1'b0, mem_write = 1'b0, halt = 1'b0;
  logic         icache_req = 1'b0, icache_hit = 1'b0, dcache_req = 1'b0, dcache_hit = 1'b0;
  logic         clr = 1'b0, rd_en = 1'b0;
  logic [2:0]   rd_sel = 3'd0;
  logic         rd_valid;
  logic [W-1:0] rd_data;
  logic [5:0]   ovf;
  logic         halted;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_cnt [6];
  logic [5:0]   m_ovf;
  logic         m_halted;
  logic [W-1:0] sb [$];

  perf_counter_unit #(.CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .reg_write(reg_write), .mem_write(mem_write), .halt(halt),
    .icache_req(icache_req), .icache_hit(icache_hit), .dcache_req(dcache_req),
    .dcache_hit(dcache_hit), .clr(clr), .rd_en(rd_en), .rd_sel(rd_sel),
    .rd_valid(rd_valid), .rd_data(rd_data), .ovf(ovf), .halted(halted)
  );

  always #5 clk = ~clk;

  // Advance one clock: update the reference model, push expected read data, then
  // pop and compare whatever the DUT presents after the edge.
  task automatic cycle();
    logic [5:0]   inc;
    logic [W-1:0] exp_rd;
    logic         was_rd, was_rst;
    was_rd  = rst_n & rd_en;
    was_rst = ~rst_n;
    inc = {dcache_req & dcache_hit, dcache_req, icache_req & icache_hit, icache_req,
           reg_write | mem_write | halt, 1'b1};
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) m_cnt[i] = '0;
      m_ovf = '0;
      m_halted = 1'b0;
      sb.delete();
    end else begin
      if (rd_en) begin
        exp_rd = '0;
        if (rd_sel < 3'd6) exp_rd = m_cnt[rd_sel];
        sb.push_back(exp_rd);
      end
      if (clr) begin
        for (int i = 0; i < 6; i++) m_cnt[i] = '0;
        m_ovf = '0;
        m_halted = 1'b0;
      end else if (!m_halted) begin
        for (int i = 0; i < 6; i++) begin
          if (inc[i]) begin
            if (m_cnt[i] == {W{1'b1}}) begin
              m_ovf[i] = 1'b1;
`ifndef PERF_SAT_EN
              m_cnt[i] = '0;
`endif
            end else begin
              m_cnt[i] = m_cnt[i] + 1;
            end
          end
        end
        if (halt) m_halted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (rd_valid !== was_rd) begin
      errors++;
      $display("FAIL rd_valid: got %b want %b", rd_valid, was_rd);
    end
    if (was_rd && sb.size() > 0) begin
      exp_rd = sb.pop_front();
      checks++;
      if (rd_data !== exp_rd) begin
        errors++;
        $display("FAIL sb_rd_data: got %0d want %0d", rd_data, exp_rd);
      end
    end
    if (was_rst) begin
      checks++;
      if (rd_data !== '0) begin
        errors++;
        $display("FAIL rst_rd_data: got %0d want 0", rd_data);
      end
    end
    checks++;
    if (ovf !== m_ovf || halted !== m_halted) begin
      errors++;
      $display("FAIL ovf_halted: got %b/%b want %b/%b", ovf, halted, m_ovf, m_halted);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic rd(input logic [2:0] sel);
    rd_en = 1'b1;
    rd_sel = sel;
    cycle();
    rd_en = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    idle(10);
    rd(3'd0);
    checks++;
    if (rd_data !== 8'd10) begin
      errors++;
      $display("FAIL reset_cycle: got %0d want 10", rd_data);
    end
    for (int s = 1; s < 6; s++) begin
      rd(3'(s));
      checks++;
      if (rd_data !== 8'd0) begin
        errors++;
        $display("FAIL reset_cnt%0d: got %0d want 0", s, rd_data);
      end
    end
  endtask

  task automatic test_inst_halt();
    do_clr();
    reg_write = 1'b1; idle(3);
    reg_write = 1'b0; mem_write = 1'b1; idle(2);
    reg_write = 1'b1; idle(1);
    reg_write = 1'b0; mem_write = 1'b0; halt = 1'b1; idle(1);
    halt = 1'b0;
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL halted_set: got %b want 1", halted);
    end
    reg_write = 1'b1; idle(5);
    reg_write = 1'b0;
    rd(3'd1);
    checks++;
    if (rd_data !== 8'd7) begin
      errors++;
      $display("FAIL inst_count: got %0d want 7", rd_data);
    end
    rd(3'd0);
    checks++;
    if (rd_data !== 8'd7) begin
      errors++;
      $display("FAIL cycle_frozen: got %0d want 7", rd_data);
    end
  endtask

  task automatic test_cache();
    do_clr();
    icache_req = 1'b1; dcache_req = 1'b1; icache_hit = 1'b1; dcache_hit = 1'b1; idle(3);
    icache_hit = 1'b0; dcache_hit = 1'b0; idle(1);
    icache_req = 1'b0; dcache_req = 1'b0; icache_hit = 1'b1; dcache_hit = 1'b1; idle(2);
    icache_hit = 1'b0; dcache_hit = 1'b0;
    // Back-to-back reads, one result per cycle.
    for (int s = 2; s < 6; s++) begin
      rd_en = 1'b1;
      rd_sel = 3'(s);
      cycle();
      checks++;
      if (rd_data !== ((s % 2 == 0) ? 8'd4 : 8'd3)) begin
        errors++;
        $display("FAIL cache_cnt%0d: got %0d want %0d", s, rd_data, (s % 2 == 0) ? 4 : 3);
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_wrap();
    do_clr();
    reg_write = 1'b1; idle(256);
    reg_write = 1'b0;
    rd(3'd1);
    checks++;
`ifdef PERF_SAT_EN
    if (rd_data !== 8'd255 || ovf[1] !== 1'b1) begin
      errors++;
      $display("FAIL sat_inst: got %0d/%b want 255/1", rd_data, ovf[1]);
    end
`else
    if (rd_data !== 8'd0 || ovf[1] !== 1'b1) begin
      errors++;
      $display("FAIL wrap_inst: got %0d/%b want 0/1", rd_data, ovf[1]);
    end
`endif
  endtask

  task automatic test_clr();
    do_clr();
    reg_write = 1'b1; idle(5);
    clr = 1'b1; rd_en = 1'b1; rd_sel = 3'd1;
    cycle();
    clr = 1'b0; rd_en = 1'b0; reg_write = 1'b0;
    checks++;
    if (rd_data !== 8'd5 || ovf !== 6'd0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL clr_read: got %0d/%b/%b want 5/0/0", rd_data, ovf, halted);
    end
    rd(3'd1);
    checks++;
    if (rd_data !== 8'd0) begin
      errors++;
      $display("FAIL clr_inst: got %0d want 0", rd_data);
    end
    halt = 1'b1; idle(1);
    halt = 1'b0; idle(3);
    do_clr();
    reg_write = 1'b1; idle(2);
    reg_write = 1'b0;
    rd(3'd1);
    checks++;
    if (rd_data !== 8'd2) begin
      errors++;
      $display("FAIL clr_rearm: got %0d want 2", rd_data);
    end
  endtask

  task automatic test_midrun_reset();
    icache_req = 1'b1; reg_write = 1'b1; idle(4);
    rst_n = 1'b0; rd_en = 1'b1; rd_sel = 3'd0;
    cycle();
    rst_n = 1'b1; rd_en = 1'b0; icache_req = 1'b0; reg_write = 1'b0;
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_rd_valid: got %b want 0", rd_valid);
    end
    rd(3'd7);
    checks++;
    if (rd_data !== 8'd0 || rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL sel7: got %0d/%b want 0/1", rd_data, rd_valid);
    end
    for (int s = 1; s < 6; s++) begin
      rd(3'(s));
      checks++;
      if (rd_data !== 8'd0) begin
        errors++;
        $display("FAIL rst_cnt%0d: got %0d want 0", s, rd_data);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 6; i++) m_cnt[i] = '0;
    m_ovf = '0;
    m_halted = 1'b0;
    test_reset();
    test_inst_halt();
    test_cache();
    test_wrap();
    test_clr();
    test_midrun_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d entries want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
